// File: rtl/cram_pkg.sv
// Shared widths, grant encoding and clear-sequencer states for the CRAM write-port arbiter.
package cram_pkg;
  localparam int CRAM_AW = 8;
  localparam int CRAM_DW = 15;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2,
    GNT_CLR  = 2'd3
  } gnt_e;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;
endpackage

// File: rtl/cram_wr_arb_if.sv
// Requester and CRAM write-port signals of the arbiter; master drives requests, slave is the arbiter.
interface cram_wr_arb_if import cram_pkg::*; #(
  parameter int AW = CRAM_AW,
  parameter int DW = CRAM_DW
) ();
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          cpu_busy;
  logic          dma_start;
  logic [AW-1:0] dma_base;
  logic          dma_valid;
  logic [DW-1:0] dma_data;
  logic          dma_ready;
  logic          clr_start;
  logic [AW-1:0] clr_first;
  logic [AW-1:0] clr_last;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic [3:0]    drop_cnt;
  logic          cram_we;
  logic [AW-1:0] cram_addr;
  logic [DW-1:0] cram_data;

  modport master (
    output cpu_we, cpu_addr, cpu_data, dma_start, dma_base, dma_valid, dma_data,
           clr_start, clr_first, clr_last, clr_color,
    input  cpu_busy, dma_ready, clr_busy, drop_cnt, cram_we, cram_addr, cram_data
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_data, dma_start, dma_base, dma_valid, dma_data,
           clr_start, clr_first, clr_last, clr_color,
    output cpu_busy, dma_ready, clr_busy, drop_cnt, cram_we, cram_addr, cram_data
  );
endinterface

// File: rtl/cram_clr_fsm.sv
// Clear-range sequencer: walks ptr from first to last (wrapping through the top of CRAM) one grant at a time.
module cram_clr_fsm import cram_pkg::*; #(
  parameter int AW = CRAM_AW,
  parameter int DW = CRAM_DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_first,
  input  logic [AW-1:0] i_last,
  input  logic [DW-1:0] i_color,
  input  logic          i_gnt,
  output logic          o_busy,
  output logic [AW-1:0] o_ptr,
  output logic [DW-1:0] o_color
);
  clr_state_e    r_state;
  clr_state_e    w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_last;
  logic [DW-1:0] r_color;
  logic          w_done;

  assign w_done  = i_gnt && (r_ptr == r_last);
  assign o_busy  = (r_state == CLR_RUN);
  assign o_ptr   = r_ptr;
  assign o_color = r_color;

  // NOTE: registers use <= so every flop samples the values from before the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= CLR_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: default first, so no path through the case leaves the output unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLR_IDLE: if (i_start) w_state_nxt = CLR_RUN;
      CLR_RUN:  if (w_done)  w_state_nxt = CLR_IDLE;
      default:  w_state_nxt = CLR_IDLE;
    endcase
  end

  // A start while running is ignored; the pointer wraps naturally in AW bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr   <= '0;
      r_last  <= '0;
      r_color <= '0;
    end else if (r_state == CLR_IDLE) begin
      if (i_start) begin
        r_ptr   <= i_first;
        r_last  <= i_last;
        r_color <= i_color;
      end
    end else if (i_gnt && !w_done) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/cram_wr_arb.sv
// CRAM write-port arbiter: CPU holding register, DMA stream, clear engine; one registered write per clock.
module cram_wr_arb import cram_pkg::*; #(
  parameter int AW         = CRAM_AW,
  parameter int DW         = CRAM_DW,
  parameter int CPU_STREAK = 2
) (
  input logic          i_clk,
  input logic          i_rst,
  cram_wr_arb_if.slave bus
);
  localparam int SW = $clog2(CPU_STREAK + 2);

  logic          r_cpu_full;
  logic [AW-1:0] r_cpu_addr;
  logic [DW-1:0] r_cpu_data;
  logic [AW-1:0] r_dma_addr;
  logic [SW-1:0] r_streak;
  logic [3:0]    r_drop_cnt;
  logic          r_cram_we;
  logic [AW-1:0] r_cram_addr;
  logic [DW-1:0] r_cram_data;
  logic          w_clr_busy;
  logic [AW-1:0] w_clr_ptr;
  logic [DW-1:0] w_clr_color;
  logic          w_cpu_mask;
  gnt_e          w_gnt;

  cram_clr_fsm #(.AW(AW), .DW(DW)) u_clr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (bus.clr_start),
    .i_first (bus.clr_first),
    .i_last  (bus.clr_last),
    .i_color (bus.clr_color),
    .i_gnt   (w_gnt == GNT_CLR),
    .o_busy  (w_clr_busy),
    .o_ptr   (w_clr_ptr),
    .o_color (w_clr_color)
  );

  // Streak saturates at CPU_STREAK, so a long CPU-only run still yields one slot once others arrive.
  always_comb begin
    w_cpu_mask = (r_streak == SW'(CPU_STREAK)) && (bus.dma_valid || w_clr_busy);
    w_gnt      = GNT_NONE;
    if (!i_rst) begin
      if (r_cpu_full && !w_cpu_mask) w_gnt = GNT_CPU;
      else if (bus.dma_valid)        w_gnt = GNT_DMA;
      else if (w_clr_busy)           w_gnt = GNT_CLR;
    end
  end

  assign bus.dma_ready = (w_gnt == GNT_DMA);
  assign bus.cpu_busy  = r_cpu_full;
  assign bus.clr_busy  = w_clr_busy;
  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.cram_we   = r_cram_we;
  assign bus.cram_addr = r_cram_addr;
  assign bus.cram_data = r_cram_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cpu_full  <= 1'b0;
      r_cpu_addr  <= '0;
      r_cpu_data  <= '0;
      r_dma_addr  <= '0;
      r_streak    <= '0;
      r_drop_cnt  <= '0;
      r_cram_we   <= 1'b0;
      r_cram_addr <= '0;
      r_cram_data <= '0;
    end else begin
      // The holding register frees on its grant, so a strobe in that same cycle refills it.
      if (w_gnt == GNT_CPU || !r_cpu_full) begin
        r_cpu_full <= bus.cpu_we;
        if (bus.cpu_we) begin
          r_cpu_addr <= bus.cpu_addr;
          r_cpu_data <= bus.cpu_data;
        end
      end else if (bus.cpu_we && r_drop_cnt != 4'hF) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end

      if (bus.dma_start)         r_dma_addr <= bus.dma_base;
      else if (w_gnt == GNT_DMA) r_dma_addr <= r_dma_addr + 1'b1;

      if (w_gnt == GNT_CPU) begin
        if (r_streak != SW'(CPU_STREAK)) r_streak <= r_streak + 1'b1;
      end else begin
        r_streak <= '0;
      end

      r_cram_we <= (w_gnt != GNT_NONE);
      case (w_gnt)
        GNT_CPU: begin r_cram_addr <= r_cpu_addr; r_cram_data <= r_cpu_data;    end
        GNT_DMA: begin r_cram_addr <= r_dma_addr; r_cram_data <= bus.dma_data;  end
        GNT_CLR: begin r_cram_addr <= w_clr_ptr;  r_cram_data <= w_clr_color;   end
        default: begin r_cram_addr <= '0;         r_cram_data <= '0;            end
      endcase
    end
  end
endmodule
